pipe_mem_arbiter: RTL

//  Shares one single-port, fixed-latency unified memory between the pipeline's

---
 rtl/pipe_mem_arbiter_if.sv | 36 +++
 rtl/pipe_mem_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter_if.sv
// Bundle of the two pipeline request ports, their stalls and the shared memory port.
// The arbiter takes the slave view; the pipeline/memory side takes the master view.
interface pipe_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_done, if_rdata, dm_done, dm_rdata, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_done, if_rdata, dm_done, dm_rdata, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and
// data memory: DM first, with a bounded DM streak so a waiting fetch is never starved.
module pipe_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  pipe_mem_arbiter_if.slave   bus
);
  localparam int LAT_W  = $clog2(MEM_LAT + 1);
  localparam int STRK_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic                owner_dm_q;
  logic                owner_we_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [STRK_W-1:0]   dm_streak_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                if_done_q;
  logic                dm_done_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;

  logic                starved;
  logic                grant_dm;
  logic                grant_if;

  // A starved arbiter still serves DM when no fetch is actually waiting.
  always_comb begin
    starved  = (dm_streak_q == STRK_W'(STARVE_MAX));
    grant_dm = bus.dm_req & (~starved | ~bus.if_req);
    grant_if = bus.if_req & ~grant_dm;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_dm_q  <= 1'b0;
      owner_we_q  <= 1'b0;
      lat_cnt_q   <= '0;
      dm_streak_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_dm) begin
            owner_dm_q  <= 1'b1;
            owner_we_q  <= bus.dm_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            dm_streak_q <= bus.if_req ? dm_streak_q + STRK_W'(1) : '0;
            state_q     <= S_ISSUE;
          end else if (grant_if) begin
            owner_dm_q  <= 1'b0;
            owner_we_q  <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            dm_streak_q <= '0;
            state_q     <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          lat_cnt_q <= LAT_W'(MEM_LAT - 1);
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          // The read word is only valid in the final wait cycle.
          if (lat_cnt_q == '0) begin
            state_q <= S_DONE;
            if (owner_dm_q) begin
              dm_done_q  <= 1'b1;
              dm_rdata_q <= owner_we_q ? '0 : bus.mem_rdata;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.stall_if  = bus.if_req & ~if_done_q;
  assign bus.stall_mem = bus.dm_req & ~dm_done_q;
endmodule
